// File: rtl/md_unit_param.sv
// -----------------------------------------------------------------------------
// md_unit_param
// Multiply/divide unit with HI/LO registers for the EX stage of the pipelined
// MIPS core. Every operation takes a fixed number of cycles. The result is
// computed when the op is launched, held while busy is high, and written to
// HI/LO on the commit edge.
//
// Build option: define MD_ACC_EN to enable MADD/MADDU/MSUB/MSUBU (ops 4-7).
// When MD_ACC_EN is undefined those ops are ignored no-ops and the
// accumulate adder is not built.
//
// Parameters:
//   WIDTH      operand and HI/LO width (product is 2*WIDTH)
//   MUL_CYCLES busy cycles for multiply-class ops (>= 1)
//   DIV_CYCLES busy cycles for divide ops (>= 1)
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   start_i      launch op (sampled only while idle)
//   op_i[2:0]    0 MULT 1 MULTU 2 DIV 3 DIVU 4 MADD 5 MADDU 6 MSUB 7 MSUBU
//   a_i          operand A / dividend / mthi-mtlo data
//   b_i          operand B / divisor
//   we_hi_i      mthi write (idle only)
//   we_lo_i      mtlo write (idle only)
//   flush_i      cancel the in-flight op
//   rd_sel_i     read select: 00 HI, 01 LO, other 0
//   rdata_o      combinational read of the selected register
//   busy_o       op in progress
//   done_o       one-cycle pulse the cycle after commit
//   div_zero_o   sticky: last committed divide had a zero divisor
// -----------------------------------------------------------------------------
module md_unit_param #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             we_hi_i,
   input  logic             we_lo_i,
   input  logic             flush_i,
   input  logic [1:0]       rd_sel_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_zero_o
);

   localparam int W2     = 2 * WIDTH;
   localparam int MAXLAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW     = $clog2(MAXLAT + 1);
   localparam logic [CW-1:0] MUL_LAT = CW'(MUL_CYCLES);
   localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Full-width product; operands are sign- or zero-extended to 2*WIDTH first.
   function automatic logic [W2-1:0] mul_full(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic             sgn);
      logic [W2-1:0] xe;
      logic [W2-1:0] ye;
      xe = {{WIDTH{sgn & x[WIDTH-1]}}, x};
      ye = {{WIDTH{sgn & y[WIDTH-1]}}, y};
      return xe * ye;
   endfunction

   // Returns {remainder, quotient}. Signed division works on magnitudes and
   // then fixes the signs, so MIN / -1 yields quotient MIN and remainder 0.
   // A zero divisor is replaced by 1 only to keep the divider well defined;
   // that result is never committed.
   function automatic logic [W2-1:0] div_full(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic             sgn);
      logic             xneg;
      logic             yneg;
      logic [WIDTH-1:0] xm;
      logic [WIDTH-1:0] ym;
      logic [WIDTH-1:0] yd;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      xneg = sgn & x[WIDTH-1];
      yneg = sgn & y[WIDTH-1];
      xm   = xneg ? -x : x;
      ym   = yneg ? -y : y;
      yd   = (ym == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : ym;
      q    = xm / yd;
      r    = xm % yd;
      if (xneg ^ yneg) q = -q;
      if (xneg)        r = -r;
      return {r, q};
   endfunction

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [W2-1:0]    res_q;
   logic             div_q;
   logic             dz_q;
   logic             done_q;
   logic             div_zero_q;

   logic [W2-1:0]    res_d;
   logic             is_div_s;
   logic             legal_s;

   assign is_div_s = (op_i[2:1] == 2'b01);

`ifdef MD_ACC_EN
   assign legal_s = 1'b1;
`else
   assign legal_s = ~op_i[2];
`endif

   // Launch-time result: product, {rem,quot}, or accumulated product.
   always_comb begin
      res_d = mul_full(a_i, b_i, ~op_i[0]);
      case (op_i)
         3'd0, 3'd1: res_d = mul_full(a_i, b_i, ~op_i[0]);
         3'd2, 3'd3: res_d = div_full(a_i, b_i, ~op_i[0]);
`ifdef MD_ACC_EN
         // HI/LO cannot change while busy, so accumulating now equals
         // accumulating at commit.
         3'd4, 3'd5: res_d = {hi_q, lo_q} + mul_full(a_i, b_i, ~op_i[0]);
         3'd6, 3'd7: res_d = {hi_q, lo_q} - mul_full(a_i, b_i, ~op_i[0]);
`endif
         default:    res_d = mul_full(a_i, b_i, ~op_i[0]);
      endcase
   end

   // Control FSM, latency counter, HI/LO and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= {CW{1'b0}};
         hi_q       <= {WIDTH{1'b0}};
         lo_q       <= {WIDTH{1'b0}};
         res_q      <= {W2{1'b0}};
         div_q      <= 1'b0;
         dz_q       <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i && !flush_i) begin
                  // start beats mthi/mtlo; an illegal op is simply dropped
                  if (legal_s) begin
                     res_q   <= res_d;
                     div_q   <= is_div_s;
                     dz_q    <= (b_i == {WIDTH{1'b0}});
                     cnt_q   <= is_div_s ? DIV_LAT : MUL_LAT;
                     state_q <= ST_RUN;
                  end
               end else begin
                  if (we_hi_i) hi_q <= a_i;
                  if (we_lo_i) lo_q <= a_i;
               end
            end
            ST_RUN: begin
               if (cnt_q == CNT_ONE) begin
                  // commit edge; takes priority over flush
                  state_q <= ST_IDLE;
                  cnt_q   <= {CW{1'b0}};
                  done_q  <= 1'b1;
                  if (div_q) begin
                     div_zero_q <= dz_q;
                     if (!dz_q) begin
                        hi_q <= res_q[W2-1:WIDTH];
                        lo_q <= res_q[WIDTH-1:0];
                     end
                  end else begin
                     hi_q <= res_q[W2-1:WIDTH];
                     lo_q <= res_q[WIDTH-1:0];
                  end
               end else if (flush_i) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= {CW{1'b0}};
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= {CW{1'b0}};
            end
         endcase
      end
   end

   // Read mux; not forwarded, reflects committed HI/LO only.
   always_comb begin
      case (rd_sel_i)
         2'b00:   rdata_o = hi_q;
         2'b01:   rdata_o = lo_q;
         default: rdata_o = {WIDTH{1'b0}};
      endcase
   end

   assign busy_o     = (state_q == ST_RUN);
   assign done_o     = done_q;
   assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_md_unit_param.sv
// -----------------------------------------------------------------------------
// tb_md_unit_param
// Scoreboard bench for md_unit_param at default parameters. The stimulus
// process runs each op, derives the expected HI/LO/div_zero from a plain
// arithmetic reference model and pushes it into a queue; a separate monitor
// pops and compares whenever done pulses. Follows MD_ACC_EN like the design.
// -----------------------------------------------------------------------------
module tb_md_unit_param;

   localparam int W   = 32;
   localparam int MUL = 5;
   localparam int DIV = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          we_hi;
   logic          we_lo;
   logic          flush;
   logic [1:0]    rd_sel;
   logic [1:0]    stim_sel;
   logic [1:0]    mon_sel;
   logic          mon_active;
   logic [W-1:0]  rdata;
   logic          busy;
   logic          done;
   logic          div_zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } exp_t;
   exp_t sb[$];

   // reference state
   logic [W-1:0] m_hi;
   logic [W-1:0] m_lo;
   logic         m_dz;

   always #5 clk = ~clk;

   assign rd_sel = mon_active ? mon_sel : stim_sel;

   md_unit_param #(.WIDTH(W), .MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_i    (start),
      .op_i       (op),
      .a_i        (a),
      .b_i        (b),
      .we_hi_i    (we_hi),
      .we_lo_i    (we_lo),
      .flush_i    (flush),
      .rd_sel_i   (rd_sel),
      .rdata_o    (rdata),
      .busy_o     (busy),
      .done_o     (done),
      .div_zero_o (div_zero)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: architectural result of one op from the instruction rules.
   task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic legal, output logic [W-1:0] nh,
                        output logic [W-1:0] nl, output logic ndz);
      int          sx, sy, q, rm;
      longint      ps;
      logic [63:0] pu, acc, r;
      sx  = x;
      sy  = y;
      ps  = longint'(sx) * longint'(sy);
      pu  = {32'd0, x} * {32'd0, y};
      acc = {m_hi, m_lo};
      r   = acc;
      ndz = m_dz;
`ifdef MD_ACC_EN
      legal = 1'b1;
`else
      legal = (o < 3'd4);
`endif
      case (o)
         3'd0: r = ps;
         3'd1: r = pu;
         3'd2, 3'd3: begin
            if (y == 32'd0) begin
               ndz = 1'b1;
            end else begin
               ndz = 1'b0;
               if (o == 3'd3) begin
                  r = {x % y, x / y};
               end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                  r = {32'd0, 32'h8000_0000};
               end else begin
                  q  = sx / sy;
                  rm = sx % sy;
                  r  = {rm, q};
               end
            end
         end
         3'd4: r = acc + ps;
         3'd5: r = acc + pu;
         3'd6: r = acc - ps;
         3'd7: r = acc - pu;
         default: r = acc;
      endcase
      if (!legal) r = acc;
      nh = r[63:32];
      nl = r[31:0];
   endtask

   // Monitor: on every done pulse compare HI, LO, div_zero against the queue head.
   initial begin
      logic [W-1:0] h, l;
      logic         done_prev;
      exp_t         e;
      mon_active = 1'b0;
      mon_sel    = 2'b00;
      done_prev  = 1'b0;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            mon_active = 1'b1;
            mon_sel = 2'b00;
            #1 h = rdata;
            mon_sel = 2'b01;
            #1 l = rdata;
            mon_active = 1'b0;
            check("done_single_cycle", {63'd0, done_prev}, 64'd0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               e = sb.pop_front();
               check("commit_hi", h, e.hi);
               check("commit_lo", l, e.lo);
               check("commit_div_zero", div_zero, e.dz);
               check("busy_at_done", busy, 1'b0);
            end
         end
         done_prev = done;
      end
   end

   // Idle read-back of the architectural state through the read port.
   task automatic read_regs(input string tag);
      @(posedge clk);
      #1 stim_sel = 2'b00;
      #1 check({tag, "_hi"}, rdata, m_hi);
      stim_sel = 2'b01;
      #1 check({tag, "_lo"}, rdata, m_lo);
      stim_sel = 2'b10;
      #1 check({tag, "_rd_other"}, rdata, 32'd0);
      stim_sel = 2'b00;
      check({tag, "_div_zero"}, div_zero, m_dz);
      check({tag, "_busy"}, busy, 1'b0);
   endtask

   task automatic wr(input logic hi_en, input logic lo_en, input logic [W-1:0] v);
      @(negedge clk);
      we_hi = hi_en; we_lo = lo_en; a = v;
      @(negedge clk);
      we_hi = 1'b0; we_lo = 1'b0;
      if (hi_en) m_hi = v;
      if (lo_en) m_lo = v;
   endtask

   // kind: 0 plain, 1 flush at cycle 'at', 2 reset at 'at',
   //       3 start during busy at 'at', 4 mthi/mtlo during busy at 'at'.
   // wlo asserts mtlo together with start.
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int kind, input int at, input logic wlo);
      int           cyc, lat, expcyc;
      logic         legal, ndz;
      logic [W-1:0] nh, nl;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y; we_lo = wlo;
      @(negedge clk);
      start = 1'b0; we_lo = 1'b0;
      model(o, x, y, legal, nh, nl, ndz);
      lat = (o == 3'd2 || o == 3'd3) ? DIV : MUL;
      if (!legal)                     expcyc = 0;
      else if (kind == 1 || kind == 2) expcyc = at;
      else                            expcyc = lat;
      if (legal && kind != 1 && kind != 2) begin
         sb.push_back('{hi: nh, lo: nl, dz: ndz});
         m_hi = nh; m_lo = nl; m_dz = ndz;
      end
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         if (cyc == at) begin
            case (kind)
               1: flush = 1'b1;
               2: reset = 1'b1;
               3: begin start = 1'b1; op = 3'd1; a = 32'h0000_1234; b = 32'h0000_0077; end
               4: begin we_hi = 1'b1; we_lo = 1'b1; a = 32'hDEAD_BEEF; end
               default: ;
            endcase
         end
         @(negedge clk);
         flush = 1'b0; reset = 1'b0; start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
      end
      check($sformatf("busy_cycles_op%0d", o), cyc, expcyc);
      if (kind == 2 && legal) begin
         m_hi = '0; m_lo = '0; m_dz = 1'b0;
         check("reset_done", done, 1'b0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [2:0]   o;
      logic [W-1:0] x, y;
      int           k, at, lat;
      reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
      we_hi = 1'b0; we_lo = 1'b0; flush = 1'b0; stim_sel = 2'b00;
      m_hi = '0; m_lo = '0; m_dz = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_done", done, 1'b0);
      read_regs("reset");

      // signed multiply: -2 * 3
      run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0, 1'b0);
      read_regs("mult");

      // divides
      run_op(3'd3, 32'd100, 32'd7, 0, 0, 1'b0);
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
      run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 0, 0, 1'b0);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);

      // divide by zero keeps HI/LO and sets the sticky flag
      wr(1'b1, 1'b0, 32'd5);
      run_op(3'd2, 32'd9, 32'd0, 0, 0, 1'b0);
      read_regs("divzero");
      run_op(3'd3, 32'd9, 32'd3, 0, 0, 1'b0);
      read_regs("divu_after_zero");

      // flush mid-op, start while busy, writes while busy
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 2, 1'b0);
      read_regs("flush");
      run_op(3'd0, 32'd7, 32'd9, 3, 3, 1'b0);
      run_op(3'd1, 32'd11, 32'd13, 4, 2, 1'b0);
      read_regs("busy_writes");

      // accumulate sequence (no-op without MD_ACC_EN)
      wr(1'b1, 1'b1, 32'd0);
      wr(1'b0, 1'b1, 32'd10);
      run_op(3'd4, 32'd3, 32'd4, 0, 0, 1'b0);
      run_op(3'd7, 32'd1, 32'd23, 0, 0, 1'b0);
      read_regs("acc");

      // reset mid-divide
      run_op(3'd2, 32'd100, 32'd3, 2, 4, 1'b0);
      read_regs("reset_mid_div");

      // start with mtlo: op runs (zero divisor keeps LO), write dropped
      wr(1'b0, 1'b1, 32'd42);
      run_op(3'd2, 32'd6, 32'd0, 0, 0, 1'b1);
      read_regs("start_vs_mtlo");

      // randomized ops
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: x = 32'h8000_0000;
            1: x = 32'hFFFF_FFFF;
            2: x = 32'($urandom_range(0, 50));
            default: x = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0: y = 32'd0;
            1: y = 32'hFFFF_FFFF;
            2: y = 32'($urandom_range(1, 20));
            default: y = $urandom;
         endcase
         lat = (o == 3'd2 || o == 3'd3) ? DIV : MUL;
         k = 0; at = 0;
         if ($urandom_range(0, 5) == 0) begin
            k = 1; at = $urandom_range(1, lat - 1);
         end
         if ($urandom_range(0, 4) == 0) wr(1'($urandom_range(0, 1)), 1'b1, $urandom);
         run_op(o, x, y, k, at, 1'b0);
      end
      read_regs("random_end");

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the EX stage of the pipelined MIPS core.
- Performs signed/unsigned multiply and divide, plus optional multiply-accumulate/subtract, over a fixed configurable latency.
- Asserts busy so hazard logic stalls HI/LO consumers; supports mthi/mtlo writes, a read mux, and cancellation of an in-flight op on pipeline flush.

Parameters:
- WIDTH, 32: operand and HI/LO width; the product is 2*WIDTH.
- MUL_CYCLES, 5: busy cycles for multiply-class ops; must be >= 1.
- DIV_CYCLES, 10: busy cycles for divide ops; must be >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  launch op; sampled only while idle
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
- a  in  WIDTH  operand A / dividend / mthi-mtlo data
- b  in  WIDTH  operand B / divisor
- we_hi  in  1  mthi: HI <= a
- we_lo  in  1  mtlo: LO <= a
- flush  in  1  cancel the in-flight op
- rd_sel  in  2  read select: 00 HI, 01 LO, other 0
- rdata  out  WIDTH  combinational read of the selected register
- busy  out  1  op in progress
- done  out  1  one-cycle pulse on commit
- div_zero  out  1  sticky flag: last divide had b == 0

Behaviour:
- Reset (synchronous, active-high) forces HI = LO = 0, busy = 0, done = 0, div_zero = 0, counter = 0, state IDLE. Reset mid-op aborts the op with no commit.
- FSM states: IDLE and RUN.
- IDLE transition: with start=1 at edge T, the block:
  - latches op;
  - computes the result into internal 2*WIDTH registers (prod, or quot/rem);
  - loads the counter with LAT (MUL_CYCLES for ops 0,1,4-7; DIV_CYCLES for ops 2,3);
  - sets busy=1 and moves to RUN.
- RUN: the counter decrements each edge.
  - The commit edge is T+LAT: HI/LO update, busy drops to 0, and done is 1 for exactly the following cycle.
  - busy is therefore high for LAT cycles.
- Arithmetic:
  - MULT/MULTU: {HI,LO} = a*b, signed/unsigned, full 2*WIDTH.
  - MADD(U): {HI,LO} = {HI,LO} + a*b.
  - MSUB(U): {HI,LO} = {HI,LO} - a*b.
  - Accumulate ops use the HI/LO value at commit time (always equal to the value at start), with modulo-2^(2*WIDTH) wrap.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Signed MIN / -1: LO = MIN, HI = 0.
- Divide by zero:
  - Still takes DIV_CYCLES; at commit HI and LO are left unchanged.
  - div_zero is set to 1 at commit.
  - Any later divide with b != 0 clears div_zero at its commit.
- Handshake and priority:
  - start while busy is ignored; the op is not queued.
  - we_hi/we_lo while busy are ignored.
  - In IDLE, if start and we_hi/we_lo are asserted together, start wins and the write is dropped.
  - we_hi and we_lo together in IDLE write both registers.
- flush:
  - While busy: next edge busy=0, state IDLE, no commit, no done, HI/LO keep their pre-op values.
  - On the commit edge itself: commit wins.
  - In IDLE, flush suppresses start in the same cycle.
- rdata is purely combinational from the current HI/LO. It shows the new value from the cycle after the commit edge and is not forwarded during busy.

Optional Feature:
- Macro MD_ACC_EN.
- Defined: ops 4-7 perform MADD/MADDU/MSUB/MSUBU as specified.
- Undefined: ops 4-7 are illegal no-ops:
  - start with op 4-7 does not assert busy or done;
  - HI and LO are unchanged;
  - the accumulate datapath is not synthesised.

Test Plan:
- Defaults: reset, then MULT a=32'hFFFFFFFE (-2), b=3 → busy high for exactly 5 cycles; HI=FFFFFFFF, LO=FFFFFFFA; done pulses once, the cycle after busy falls.
- DIVU a=100, b=7 → LO=14, HI=2 after 10 busy cycles. Then DIV a=-7, b=2 → LO=FFFFFFFD, HI=FFFFFFFF.
- mthi a=5, then DIV a=9, b=0 → HI stays 5, LO unchanged, div_zero=1. Then DIVU 9/3 → LO=3, HI=0, div_zero=0.
- MULTU a=b=32'hFFFFFFFF, then assert flush 2 cycles after start → busy drops next edge, no done, HI/LO retain the prior values. A start during busy is ignored, with no second commit.
- With MD_ACC_EN: HI=0, LO=10, then MADD a=3, b=4 → LO=22, HI=0. Then MSUBU a=1, b=23 → {HI,LO}=64'hFFFFFFFF_FFFFFFFF. Without the macro, the same sequence leaves HI/LO unchanged and busy never rises.
- Reset asserted mid-DIV (cycle 4) → HI=LO=0, busy=0 next edge. start and we_lo in the same idle cycle → op runs, LO write dropped.
